// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control slice.
// STOPWATCH_BCD_EN selects BCD (tens in [7:4], units in [3:0]) display encoding instead of binary.
package stopwatch_pkg;

  typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;

  localparam int CS_MAX  = 99;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int DISP_W  = 8;

  function automatic logic [DISP_W-1:0] to_disp(input logic [6:0] v);
`ifdef STOPWATCH_BCD_EN
    logic [3:0] tens;
    logic [3:0] units;
    tens  = 4'(v / 7'd10);
    units = 4'(v % 7'd10);
    return {tens, units};
`else
    return {1'b0, v};
`endif
  endfunction

endpackage

// File: rtl/stopwatch_time_counter.sv
// Prescaler plus mm:ss.cc binary counter chain; wrap pulses on the 59:59.99 -> 00:00.00 step.
module stopwatch_time_counter
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_CS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clear,
  input  logic       i_count_en,
  output logic [6:0] o_cs,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic       o_wrap
);

  logic [7:0] r_presc;
  logic [6:0] r_cs;
  logic [5:0] r_sec;
  logic [5:0] r_min;
  logic       w_presc_tc;
  logic       w_cs_tc;
  logic       w_sec_tc;
  logic       w_min_tc;

  assign w_presc_tc = (r_presc == 8'(TICKS_PER_CS - 1));
  assign w_cs_tc    = (r_cs == 7'(CS_MAX));
  assign w_sec_tc   = (r_sec == 6'(SEC_MAX));
  assign w_min_tc   = (r_min == 6'(MIN_MAX));

  // Clear has priority over a coincident tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_cs    <= '0;
      r_sec   <= '0;
      r_min   <= '0;
    end else if (i_clear) begin
      r_presc <= '0;
      r_cs    <= '0;
      r_sec   <= '0;
      r_min   <= '0;
    end else if (i_count_en) begin
      if (w_presc_tc) begin
        r_presc <= '0;
        if (w_cs_tc) begin
          r_cs <= '0;
          if (w_sec_tc) begin
            r_sec <= '0;
            r_min <= w_min_tc ? 6'd0 : r_min + 6'd1;
          end else begin
            r_sec <= r_sec + 6'd1;
          end
        end else begin
          r_cs <= r_cs + 7'd1;
        end
      end else begin
        r_presc <= r_presc + 8'd1;
      end
    end
  end

  assign o_wrap = i_count_en & ~i_clear & w_presc_tc & w_cs_tc & w_sec_tc & w_min_tc;
  assign o_cs   = r_cs;
  assign o_sec  = r_sec;
  assign o_min  = r_min;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch FSM (IDLE/RUN/LAP/PAUSE), lap register and registered display mux.
// Display encoding is BCD when STOPWATCH_BCD_EN is defined, binary otherwise.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_CS = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_1ms,
  input  logic              start_stop_edge,
  input  logic              lap_reset_edge,
  output logic              running,
  output logic              lap_active,
  output logic              overflow,
  output logic [DISP_W-1:0] disp_cs,
  output logic [DISP_W-1:0] disp_sec,
  output logic [DISP_W-1:0] disp_min
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_clk_1ms_prev;
  logic [6:0] r_lap_cs;
  logic [5:0] r_lap_sec;
  logic [5:0] r_lap_min;
  logic       w_tick;
  logic       w_count_en;
  logic       w_clear;
  logic       w_lap_latch;
  logic       w_wrap;
  logic [6:0] w_cs;
  logic [5:0] w_sec;
  logic [5:0] w_min;

  // start_stop takes precedence whenever both pulses arrive together.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start_stop_edge) w_state_nxt = RUN;
      RUN:     if (start_stop_edge) w_state_nxt = PAUSE;
               else if (lap_reset_edge) w_state_nxt = LAP;
      LAP:     if (start_stop_edge) w_state_nxt = PAUSE;
               else if (lap_reset_edge) w_state_nxt = RUN;
      PAUSE:   if (start_stop_edge) w_state_nxt = RUN;
               else if (lap_reset_edge) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_tick      = clk_1ms & ~r_clk_1ms_prev;
  assign w_count_en  = w_tick & ((r_state == RUN) | (r_state == LAP));
  assign w_clear     = (r_state == PAUSE) & lap_reset_edge & ~start_stop_edge;
  assign w_lap_latch = (r_state == RUN) & lap_reset_edge & ~start_stop_edge;

  stopwatch_time_counter #(
    .TICKS_PER_CS(TICKS_PER_CS)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_clear),
    .i_count_en(w_count_en),
    .o_cs      (w_cs),
    .o_sec     (w_sec),
    .o_min     (w_min),
    .o_wrap    (w_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_clk_1ms_prev <= 1'b0;
      running        <= 1'b0;
      lap_active     <= 1'b0;
      overflow       <= 1'b0;
      r_lap_cs       <= '0;
      r_lap_sec      <= '0;
      r_lap_min      <= '0;
      disp_cs        <= '0;
      disp_sec       <= '0;
      disp_min       <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_clk_1ms_prev <= clk_1ms;
      running        <= (w_state_nxt == RUN) | (w_state_nxt == LAP);
      lap_active     <= (w_state_nxt == LAP);
      if (w_clear) begin
        overflow <= 1'b0;
      end else if (w_wrap) begin
        overflow <= 1'b1;
      end
      if (w_lap_latch) begin
        r_lap_cs  <= w_cs;
        r_lap_sec <= w_sec;
        r_lap_min <= w_min;
      end
      // Display follows the current (registered) state, so it lags a state change by one clk.
      if (r_state == LAP) begin
        disp_cs  <= to_disp(r_lap_cs);
        disp_sec <= to_disp({1'b0, r_lap_sec});
        disp_min <= to_disp({1'b0, r_lap_min});
      end else begin
        disp_cs  <= to_disp(w_cs);
        disp_sec <= to_disp({1'b0, w_sec});
        disp_min <= to_disp({1'b0, w_min});
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl (TICKS_PER_CS = 10).
module tb_stopwatch_ctrl;

  logic       clk;
  logic       rst;
  logic       clk_1ms;
  logic       start_stop_edge;
  logic       lap_reset_edge;
  logic       running;
  logic       lap_active;
  logic       overflow;
  logic [7:0] disp_cs;
  logic [7:0] disp_sec;
  logic [7:0] disp_min;

  int n_checks;
  int n_errors;

  stopwatch_ctrl #(.TICKS_PER_CS(10)) dut (
    .clk            (clk),
    .rst            (rst),
    .clk_1ms        (clk_1ms),
    .start_stop_edge(start_stop_edge),
    .lap_reset_edge (lap_reset_edge),
    .running        (running),
    .lap_active     (lap_active),
    .overflow       (overflow),
    .disp_cs        (disp_cs),
    .disp_sec       (disp_sec),
    .disp_min       (disp_min)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] enc(input int v);
`ifdef STOPWATCH_BCD_EN
    return 8'(((v / 10) << 4) | (v % 10));
`else
    return 8'(v);
`endif
  endfunction

  task automatic chk_time(input string tag, input int m, input int s, input int c);
    chk({tag, "_min"}, 32'(disp_min), 32'(enc(m)));
    chk({tag, "_sec"}, 32'(disp_sec), 32'(enc(s)));
    chk({tag, "_cs"},  32'(disp_cs),  32'(enc(c)));
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      clk_1ms = 1'b1;
      @(negedge clk);
      clk_1ms = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic press(input logic ss, input logic lr);
    start_stop_edge = ss;
    lap_reset_edge  = lr;
    @(negedge clk);
    start_stop_edge = 1'b0;
    lap_reset_edge  = 1'b0;
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    rst             = 1'b1;
    clk_1ms         = 1'b0;
    start_stop_edge = 1'b0;
    lap_reset_edge  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_lap", 32'(lap_active), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk_time("rst", 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);

    // lap_reset in IDLE is ignored; ticks in IDLE do not count
    press(1'b0, 1'b1);
    chk("idle_lr_running", 32'(running), 32'd0);
    tick_n(20);
    chk_time("idle_ticks", 0, 0, 0);

    // 1: start and count 250 ticks
    press(1'b1, 1'b0);
    chk("t1_running", 32'(running), 32'd1);
    chk("t1_lap", 32'(lap_active), 32'd0);
    tick_n(250);
    chk_time("t1", 0, 0, 25);

    // 2: lap freeze at 00:01.37 then release after 500 ticks
    tick_n(1120);
    chk_time("t2_pre", 0, 1, 37);
    press(1'b0, 1'b1);
    chk("t2_lap_on", 32'(lap_active), 32'd1);
    chk("t2_running", 32'(running), 32'd1);
    tick_n(500);
    chk_time("t2_hold", 0, 1, 37);
    press(1'b0, 1'b1);
    chk("t2_lap_off", 32'(lap_active), 32'd0);
    @(negedge clk);
    chk_time("t2_live", 0, 1, 87);

    // 3: pause with prescaler at 7, resume keeps the sub-cs phase
    tick_n(7);
    press(1'b1, 1'b0);
    chk("t3_paused", 32'(running), 32'd0);
    tick_n(300);
    chk_time("t3_pause", 0, 1, 87);
    press(1'b1, 1'b0);
    chk("t3_resumed", 32'(running), 32'd1);
    tick_n(2);
    chk_time("t3_r2", 0, 1, 87);
    tick_n(3);
    chk_time("t3_r5", 0, 1, 88);

    // 5: simultaneous presses, start_stop wins
    press(1'b1, 1'b1);
    chk("t5_run_pause", 32'(running), 32'd0);
    chk("t5_no_lap", 32'(lap_active), 32'd0);
    @(negedge clk);
    chk_time("t5_pause", 0, 1, 88);
    press(1'b1, 1'b1);
    chk("t5_pause_run", 32'(running), 32'd1);
    chk("t5_no_lap2", 32'(lap_active), 32'd0);
    @(negedge clk);
    chk_time("t5_kept", 0, 1, 88);

    // Tick coinciding with RUN->PAUSE is counted (prescaler 9 -> cs+1)
    tick_n(7);
    chk_time("edge_pre", 0, 1, 88);
    clk_1ms = 1'b1;
    press(1'b1, 1'b0);
    clk_1ms = 1'b0;
    @(negedge clk);
    chk("edge_paused", 32'(running), 32'd0);
    chk_time("edge_run_pause", 0, 1, 89);

    // Tick coinciding with PAUSE->RUN is not counted
    clk_1ms = 1'b1;
    press(1'b1, 1'b0);
    clk_1ms = 1'b0;
    @(negedge clk);
    tick_n(9);
    chk_time("edge_pause_run9", 0, 1, 89);
    tick_n(1);
    chk_time("edge_pause_run10", 0, 1, 90);

    // 4: overflow wrap from a preloaded 59:59.99 (prescaler is 0 here)
    press(1'b1, 1'b0);
    dut.u_cnt.r_cs  = 7'd99;
    dut.u_cnt.r_sec = 6'd59;
    dut.u_cnt.r_min = 6'd59;
    @(negedge clk);
    @(negedge clk);
    chk_time("t4_preload", 59, 59, 99);
    chk("t4_ovf0", 32'(overflow), 32'd0);
    press(1'b1, 1'b0);
    tick_n(9);
    chk_time("t4_pre_wrap", 59, 59, 99);
    chk("t4_ovf_pre", 32'(overflow), 32'd0);
    tick_n(1);
    chk_time("t4_wrap", 0, 0, 0);
    chk("t4_ovf1", 32'(overflow), 32'd1);
    tick_n(10);
    chk_time("t4_after", 0, 0, 1);
    chk("t4_ovf_sticky", 32'(overflow), 32'd1);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk("t4_idle_running", 32'(running), 32'd0);
    chk("t4_idle_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    chk_time("t4_idle", 0, 0, 0);

    // 6: async reset mid-run at 00:12.34
    press(1'b1, 1'b0);
    tick_n(12340);
    chk_time("t6_pre", 0, 12, 34);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_running", 32'(running), 32'd0);
    chk("t6_lap", 32'(lap_active), 32'd0);
    chk("t6_ovf", 32'(overflow), 32'd0);
    chk_time("t6_async", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tick_n(20);
    chk("t6_idle_running", 32'(running), 32'd0);
    chk_time("t6_idle", 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
